// File: rtl/conv_pkg.sv
// Shared constants for the K=3 rate-1/2 convolutional code.
// Generators and symbol bit order are common to encoder and decoder.
package conv_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam logic [K-1:0] G2 = 3'b111;

  localparam int SYM_C1 = 1;
  localparam int SYM_C2 = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_e;

  // Taps are {u[n], u[n-1], u[n-2]} masked by each generator.
  function automatic logic [1:0] conv_sym(
    input logic         u,
    input logic [K-2:0] sr
  );
    logic [K-1:0] w;
    logic [1:0]   s;
    w = {u, sr};
    s = '0;
    s[SYM_C1] = ^(w & G1);
    s[SYM_C2] = ^(w & G2);
    return s;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and generator XORs.
// clr_i forces the trellis back to state 0 after the current symbol.
module conv_enc_core
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       u_i,
  output logic [1:0] sym_o
);

  logic [K-2:0] sr_q;
  logic [K-2:0] sr_d;

  assign sym_o = conv_sym(u_i, sr_q);

  // Next trellis state: shift on a generated symbol, clear wins.
  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = {u_i, sr_q[K-2]};
    end
  end

  // Trellis state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/conv_enc_frame.sv
// Framed K=3 rate-1/2 encoder with a single-register output slot.
// CONV_ENC_TAIL_EN adds two zero tail symbols per frame.
module conv_enc_frame
  import conv_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_sof,
  output logic       out_eof
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

  enc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
`ifdef CONV_ENC_TAIL_EN
  logic             tcnt_q, tcnt_d;
`endif

  logic       vld_q;
  logic [1:0] sym_q;
  logic       sof_q, eof_q;

  logic       free;
  logic       gen;
  logic       clr;
  logic       u;
  logic       sof_d, eof_d;
  logic [1:0] sym;

  assign free      = !vld_q || out_ready;
  assign out_valid = vld_q;
  assign out_sym   = sym_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;

  conv_enc_core u_core (
    .clk   (clk),
    .rst   (rst),
    .en_i  (gen),
    .clr_i (clr),
    .u_i   (u),
    .sym_o (sym)
  );

  // Frame FSM: decides when a symbol is generated and its flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_nxt  = cnt_q + CNT_W'(1);
`ifdef CONV_ENC_TAIL_EN
    tcnt_d   = tcnt_q;
`endif
    in_ready = 1'b0;
    gen      = 1'b0;
    clr      = 1'b0;
    u        = in_bit;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    unique case (state_q)
      IDLE, DATA: begin
        in_ready = free;
        if (in_valid && free) begin
          gen     = 1'b1;
          sof_d   = (state_q == IDLE);
          cnt_d   = cnt_nxt;
          state_d = DATA;
          if (cnt_nxt == LAST) begin
`ifdef CONV_ENC_TAIL_EN
            state_d = TAIL;
            tcnt_d  = 1'b0;
`else
            eof_d   = 1'b1;
            clr     = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL: begin
        u = 1'b0;
        if (free) begin
          gen    = 1'b1;
          tcnt_d = 1'b1;
          if (tcnt_q) begin
            eof_d   = 1'b1;
            clr     = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef CONV_ENC_TAIL_EN
      tcnt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CONV_ENC_TAIL_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Output slot: reload when freed, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      sym_q <= 2'b00;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end else if (gen) begin
      vld_q <= 1'b1;
      sym_q <= sym;
      sof_q <= sof_d;
      eof_q <= eof_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_enc_frame.sv
// Scoreboard bench for conv_enc_frame with a frame-level reference.
// Runs in either tail mode, following CONV_ENC_TAIL_EN.
module tb_conv_enc_frame;

  localparam int FL = 4;
`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sym;
    logic       sof;
    logic       eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_sof;
  logic       out_eof;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   acc    = 0;
  exp_t q[$];
  bit   fb[$];
  bit   tput   = 1'b0;
  bit   seen   = 1'b0;
  bit   hold   = 1'b0;
  exp_t held;
  bit   pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  conv_enc_frame #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Code symbol of frame position n from the generator equations.
  function automatic exp_t mk(input int n, input bit s, input bit e);
    int u0, u1, u2;
    exp_t r;
    u0 = int'(fb[n]);
    u1 = (n >= 1) ? int'(fb[n-1]) : 0;
    u2 = (n >= 2) ? int'(fb[n-2]) : 0;
    r.sym = {1'((u0 + u2) % 2), 1'((u0 + u1 + u2) % 2)};
    r.sof = s;
    r.eof = e;
    return r;
  endfunction

  // Reference: expected symbols queued as bits are accepted.
  always @(negedge clk) begin
    int n;
    if (rst) begin
      q.delete();
      fb.delete();
      acc = 0;
    end else if (in_valid && in_ready) begin
      acc++;
      fb.push_back(in_bit);
      n = fb.size() - 1;
      q.push_back(mk(n, n == 0, !TAIL_ON && n == FL - 1));
      if (n == FL - 1) begin
        if (TAIL_ON) begin
          fb.push_back(1'b0);
          q.push_back(mk(n + 1, 1'b0, 1'b0));
          fb.push_back(1'b0);
          q.push_back(mk(n + 2, 1'b0, 1'b1));
        end
        fb.delete();
      end
    end
  end

  // Monitor: compares every transferred symbol and stall holds.
  always @(negedge clk) begin
    exp_t a, e;
    a = {out_sym, out_sof, out_eof};
    if (rst) begin
      hold = 1'b0;
      seen = 1'b0;
    end else begin
      if (hold)
        chk(out_valid && a == held, "hold", {out_valid, a}, {1'b1, held});
      if (tput && out_valid) seen = 1'b1;
      if (tput && seen)
        chk(out_valid == 1'b1, "throughput", out_valid, 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk(1'b0, "extra_symbol", a, 0);
        end else begin
          e = q.pop_front();
          chk(a == e, "symbol", a, e);
        end
      end
      hold = out_valid && !out_ready;
      held = a;
    end
  end

  task automatic check_reset_state();
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    chk(out_sym == 2'b00, "rst_out_sym", out_sym, 0);
    chk(out_sof == 1'b0, "rst_out_sof", out_sof, 0);
    chk(out_eof == 1'b0, "rst_out_eof", out_eof, 0);
  endtask

  task automatic run_pattern(input int cycles);
    tput      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = pat[acc % 4];
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 in_bit = pat[acc % 4];
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();

    run_pattern(30);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (acc % FL == 2) break;
    end
    tput     = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();
    run_pattern(2 * (FL + 2) + 3);
    tput = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst       = (i == 1111 || i == 2222);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (rst) begin
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state();
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk(q.size() == 0, "drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
